// File: rtl/hex_scan_controller_pkg.sv
// Shared definitions for the seven-segment scan controller: FSM encoding,
// default timing constants and the leading-zero suppression helper.
package hex_scan_controller_pkg;

  typedef enum logic {
    STATE_BLANK = 1'b0,
    STATE_DRIVE = 1'b1
  } scan_state_t;

  localparam int DEFAULT_REFRESH_DIV  = 50000;
  localparam int DEFAULT_BLANK_CYCLES = 2;
  localparam int MAX_DIGITS           = 8;

  // Bit i set when digit i is a leading zero; digit 0 is never suppressed.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [4*MAX_DIGITS-1:0] val,
    input logic                    lz_en,
    input int                      num_digits
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  all_zero;
    mask     = {MAX_DIGITS{1'b0}};
    all_zero = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < num_digits) begin
        all_zero = all_zero & (val[4*i +: 4] == 4'h0);
        mask[i]  = lz_en & all_zero;
      end else begin
        mask[i] = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/hex_scan_controller_scan_timer.sv
// Slot timer: down-counter that pulses slot_done on the last cycle of a
// slot whose length is SHORT_LEN or LONG_LEN depending on sel_long.
module hex_scan_controller_scan_timer #(
  parameter int SHORT_LEN = 2,
  parameter int LONG_LEN  = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic sel_long,
  output logic slot_done
);

  localparam int MAX_LEN = (LONG_LEN > SHORT_LEN) ? LONG_LEN : SHORT_LEN;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_LEN - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic [CNT_W-1:0] len_last_s;

  // Zero marks the first cycle of a slot; the count is loaded there and
  // runs down to one, so a freshly reset timer starts a whole slot.
  always_comb begin
    len_last_s   = sel_long ? LONG_LAST : SHORT_LAST;
    count_next_s = count_r;
    if (count_r == CNT_ZERO) begin
      slot_done = (len_last_s == CNT_ZERO);
    end else begin
      slot_done = (count_r == CNT_ONE);
    end
    if (slot_done) begin
      count_next_s = CNT_ZERO;
    end else if (count_r == CNT_ZERO) begin
      count_next_s = len_last_s;
    end else begin
      count_next_s = count_r - CNT_ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= CNT_ZERO;
    end else begin
      count_r <= count_next_s;
    end
  end

endmodule

// File: rtl/hex_scan_controller.sv
// Multiplexed seven-segment scan controller with frame-synchronous value
// updates, blanking guard between digits and leading-zero suppression.
module hex_scan_controller
  import hex_scan_controller_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = DEFAULT_REFRESH_DIV,
  parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_suppress,
  output logic                    ready,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [3:0]              nibble,
  output logic                    frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(1'b0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);

  scan_state_t             state_r, next_state_s;
  logic [IDX_W-1:0]        idx_r, next_idx_s;
  logic                    slot_done_s, wrap_s;
  logic [4*NUM_DIGITS-1:0] active_val_r, pend_val_r, nib_src_s;
  logic [NUM_DIGITS-1:0]   active_mask_r, pend_mask_r, sel_next_s;
  logic                    active_lz_r, pend_lz_r, pend_valid_r, xfer_r;
  logic [3:0]              nib_next_s;
  logic [MAX_DIGITS-1:0]   supp_full_s;

  hex_scan_controller_scan_timer #(
    .SHORT_LEN (BLANK_CYCLES),
    .LONG_LEN  (REFRESH_DIV)
  ) u_scan_timer (
    .clock     (clock),
    .reset     (reset),
    .sel_long  (state_r == STATE_DRIVE),
    .slot_done (slot_done_s)
  );

  assign supp_full_s = MAX_DIGITS'(active_mask_r)
                     | lz_mask((4*MAX_DIGITS)'(active_val_r), active_lz_r, NUM_DIGITS);

  // Next-state logic and the values the registered outputs take next.
  always_comb begin
    next_state_s = state_r;
    next_idx_s   = idx_r;
    wrap_s       = 1'b0;
    case (state_r)
      STATE_BLANK: begin
        if (slot_done_s) begin
          next_state_s = STATE_DRIVE;
        end else begin
          next_state_s = STATE_BLANK;
        end
      end
      STATE_DRIVE: begin
        if (slot_done_s) begin
          next_state_s = STATE_BLANK;
          if (idx_r == LAST_IDX) begin
            next_idx_s = IDX_ZERO;
            wrap_s     = 1'b1;
          end else begin
            next_idx_s = idx_r + IDX_ONE;
          end
        end else begin
          next_state_s = STATE_DRIVE;
        end
      end
      default: begin
        next_state_s = STATE_BLANK;
        next_idx_s   = IDX_ZERO;
      end
    endcase

    // At the frame boundary digit 0 already takes its nibble from pending.
    nib_src_s  = (wrap_s && pend_valid_r) ? pend_val_r : active_val_r;
    nib_next_s = nib_src_s[4*next_idx_s +: 4];

    sel_next_s = {NUM_DIGITS{1'b1}};
    if ((next_state_s == STATE_DRIVE) && !supp_full_s[next_idx_s]) begin
      sel_next_s[next_idx_s] = 1'b0;
    end else begin
      sel_next_s = {NUM_DIGITS{1'b1}};
    end
  end

  // Scan state, registered outputs and the load/frame handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= STATE_BLANK;
      idx_r         <= IDX_ZERO;
      digit_sel     <= {NUM_DIGITS{1'b1}};
      nibble        <= 4'h0;
      frame_tick    <= 1'b0;
      ready         <= 1'b1;
      active_val_r  <= {(4*NUM_DIGITS){1'b0}};
      active_mask_r <= {NUM_DIGITS{1'b0}};
      active_lz_r   <= 1'b0;
      pend_val_r    <= {(4*NUM_DIGITS){1'b0}};
      pend_mask_r   <= {NUM_DIGITS{1'b0}};
      pend_lz_r     <= 1'b0;
      pend_valid_r  <= 1'b0;
      xfer_r        <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      idx_r      <= next_idx_s;
      digit_sel  <= sel_next_s;
      frame_tick <= wrap_s;
      if (next_state_s == STATE_BLANK) begin
        nibble <= nib_next_s;
      end
      // ready high implies nothing pending, so these branches never overlap.
      if (load && ready) begin
        pend_val_r   <= value;
        pend_mask_r  <= blank_mask;
        pend_lz_r    <= lz_suppress;
        pend_valid_r <= 1'b1;
        ready        <= 1'b0;
      end else if (wrap_s && pend_valid_r) begin
        active_val_r  <= pend_val_r;
        active_mask_r <= pend_mask_r;
        active_lz_r   <= pend_lz_r;
        pend_valid_r  <= 1'b0;
        xfer_r        <= 1'b1;
      end else if (xfer_r) begin
        xfer_r <= 1'b0;
        ready  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hex_scan_controller.sv
// Bench for hex_scan_controller (4 digits, 4-cycle drive, 1-cycle blank):
// frame-position model checked every cycle plus hand-computed spot values.
module tb_hex_scan_controller;

  localparam int ND    = 4;
  localparam int SLOT  = 5;
  localparam int FRAME = ND * SLOT;

  logic          clock;
  logic          reset;
  logic          load;
  logic [15:0]   value;
  logic [3:0]    blank_mask;
  logic          lz_suppress;
  logic          ready;
  logic [3:0]    digit_sel;
  logic [3:0]    nibble;
  logic          frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: cycle number since reset and displayed/pending contents.
  int          t = 0;
  bit          live = 1'b0;
  logic [15:0] m_val, p_val;
  logic [3:0]  m_mask, p_mask;
  logic        m_lz, p_lz, p_valid, m_ready, acc;
  int          xfer_t;
  int          cp, cslot, coff;
  logic [3:0]  esel, enib;
  logic        etick;

  logic [3:0] walk_tab [0:19] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hE,
                                  4'hF, 4'hD, 4'hD, 4'hD, 4'hD,
                                  4'hF, 4'hB, 4'hB, 4'hB, 4'hB,
                                  4'hF, 4'h7, 4'h7, 4'h7, 4'h7};

  hex_scan_controller #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .value       (value),
    .blank_mask  (blank_mask),
    .lz_suppress (lz_suppress),
    .ready       (ready),
    .digit_sel   (digit_sel),
    .nibble      (nibble),
    .frame_tick  (frame_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  function automatic logic is_supp(input int d);
    return m_mask[d] || (m_lz && d > 0 && ((m_val >> (4*d)) == 16'h0));
  endfunction

  // Model: a load accepted while ready is shown from the first frame
  // boundary strictly after the cycle it becomes pending.
  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        t = 0; live = 1'b1; m_val = 16'h0; m_mask = 4'h0; m_lz = 1'b0;
        p_valid = 1'b0; m_ready = 1'b1; xfer_t = 0;
      end else if (live) begin
        acc = load && m_ready;
        t++;
        if (p_valid && t == xfer_t) begin
          m_val = p_val; m_mask = p_mask; m_lz = p_lz; p_valid = 1'b0;
        end
        if (!m_ready && !p_valid && t == xfer_t + 1) m_ready = 1'b1;
        if (acc) begin
          p_val = value; p_mask = blank_mask; p_lz = lz_suppress;
          p_valid = 1'b1; m_ready = 1'b0;
          xfer_t = (t / FRAME + 1) * FRAME;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clock);
      if (live) begin
        cp    = t % FRAME;
        cslot = cp / SLOT;
        coff  = cp % SLOT;
        esel  = 4'hF;
        if (coff != 0 && !is_supp(cslot)) esel[cslot] = 1'b0;
        enib  = m_val[cslot*4 +: 4];
        etick = (t > 0 && cp == 0);
        check("model_digit_sel", digit_sel, esel);
        check("model_nibble", nibble, enib);
        check("model_frame_tick", frame_tick, etick);
        check("model_ready", ready, m_ready);
      end
    end
  end

  task automatic do_load(input logic [15:0] v, input logic [3:0] m, input logic lz);
    load = 1'b1; value = v; blank_mask = m; lz_suppress = lz;
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic wait_tick(input string name);
    int n;
    n = 0;
    while (frame_tick !== 1'b1 && n < 3 * FRAME) begin
      @(negedge clock);
      n++;
    end
    check(name, frame_tick, 1'b1);
  endtask

  task automatic advance_to(input int pos);
    int n;
    n = 0;
    while (t % FRAME != pos && n < 2 * FRAME) begin
      @(negedge clock);
      n++;
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; value = 16'h0; blank_mask = 4'h0; lz_suppress = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_sel", digit_sel, 4'hF);
    check("reset_ready", ready, 1'b1);
    reset = 1'b0;

    // Idle walk with all-zero display.
    for (int i = 0; i < 20; i++) begin
      check("walk_sel", digit_sel, walk_tab[i]);
      check("walk_nibble", nibble, 4'h0);
      @(negedge clock);
    end
    check("tick_t20", frame_tick, 1'b1);

    // Plain load shows F,7,A,3 from the next frame.
    do_load(16'h3A7F, 4'h0, 1'b0);
    check("ready_after_load", ready, 1'b0);
    wait_tick("tick_3a7f");
    check("nib_d0_3a7f", nibble, 4'hF);
    check("ready_at_tick", ready, 1'b0);
    @(negedge clock);
    check("ready_after_tick", ready, 1'b1);
    repeat (4) @(negedge clock);
    check("nib_d1_3a7f", nibble, 4'h7);
    repeat (5) @(negedge clock);
    check("nib_d2_3a7f", nibble, 4'hA);
    repeat (5) @(negedge clock);
    check("nib_d3_3a7f", nibble, 4'h3);

    // Leading-zero suppression of 0042.
    do_load(16'h0042, 4'h0, 1'b1);
    wait_tick("tick_0042");
    @(negedge clock);
    check("lz42_d0_sel", digit_sel, 4'hE);
    check("lz42_d0_nib", nibble, 4'h2);
    repeat (5) @(negedge clock);
    check("lz42_d1_sel", digit_sel, 4'hD);
    check("lz42_d1_nib", nibble, 4'h4);
    repeat (5) @(negedge clock);
    check("lz42_d2_sel", digit_sel, 4'hF);
    repeat (5) @(negedge clock);
    check("lz42_d3_sel", digit_sel, 4'hF);

    // All zeros with suppression, then mask digit 0 too.
    do_load(16'h0000, 4'h0, 1'b1);
    wait_tick("tick_0000");
    @(negedge clock);
    check("lz0_d0_sel", digit_sel, 4'hE);
    check("lz0_d0_nib", nibble, 4'h0);
    repeat (5) @(negedge clock);
    check("lz0_d1_sel", digit_sel, 4'hF);
    do_load(16'h0000, 4'h1, 1'b1);
    wait_tick("tick_mask");
    @(negedge clock);
    check("mask_d0_sel", digit_sel, 4'hF);

    // Second load while busy is dropped.
    do_load(16'h2222, 4'h0, 1'b0);
    do_load(16'h1111, 4'h0, 1'b0);
    check("ready_busy", ready, 1'b0);
    wait_tick("tick_2222");
    check("nib_2222", nibble, 4'h2);
    repeat (20) @(negedge clock);
    check("nib_2222_next", nibble, 4'h2);
    check("tick_2222_next", frame_tick, 1'b1);

    // Load accepted on the boundary edge waits one more frame.
    advance_to(FRAME - 1);
    do_load(16'h9876, 4'h0, 1'b0);
    check("bnd_tick", frame_tick, 1'b1);
    check("bnd_old_nib", nibble, 4'h2);
    check("bnd_ready", ready, 1'b0);
    repeat (20) @(negedge clock);
    check("bnd_new_nib", nibble, 4'h6);
    @(negedge clock);
    check("bnd_ready_back", ready, 1'b1);

    // Reset during digit 2 drive discards the pending value.
    do_load(16'h5555, 4'h0, 1'b0);
    advance_to(12);
    check("pre_reset_sel", digit_sel, 4'hB);
    reset = 1'b1;
    @(negedge clock);
    check("rst_sel", digit_sel, 4'hF);
    check("rst_ready", ready, 1'b1);
    check("rst_nib", nibble, 4'h0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_sel", digit_sel, 4'hE);
    check("post_rst_nib", nibble, 4'h0);
    repeat (39) @(negedge clock);
    check("post_rst_tick", frame_tick, 1'b1);
    check("post_rst_nib2", nibble, 4'h0);
    repeat (5) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish (t=%0d)", t);
    $fatal(1, "watchdog");
  end

endmodule
